micro_sequencer: RTL

Microprogrammed control unit for the bus-based RISC-V datapath. Holds a writable 64-entry control store and steps a micro-program counter (uPC) through it: each cycle it emits the current microinstruction's control fields (including ImmSel for the immediate generator and the bus load/enable strobes), then picks the next uPC by sequential step, spin-on-busy, opcode dispatch, conditional branch or halt. Sits between the instruction register/memory handshake and every datapath load/enable point.

---
 rtl/micro_pkg.sv | 54 +++++
 rtl/micro_sequencer_if.sv | 31 +++
 rtl/micro_sequencer_ucode_store.sv | 27 ++
 rtl/micro_sequencer.sv | 90 +++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the microprogrammed sequencer: microinstruction layout,
// next-address encodings, immediate-format selects and strobe bit positions.
package micro_pkg;

    localparam int UW_DEF = 24;
    localparam int AW_DEF = 6;
    localparam int CS_DEPTH = 1 << AW_DEF;

    localparam int IMM_HI = 23;
    localparam int IMM_LO = 22;
    localparam int STB_HI = 21;
    localparam int STB_LO = 14;
    localparam int ALU_HI = 13;
    localparam int ALU_LO = 10;
    localparam int UBR_HI = 9;
    localparam int UBR_LO = 7;
    localparam int TGT_HI = 6;
    localparam int TGT_LO = 1;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam int STB_LDIR  = 7;
    localparam int STB_LDA   = 6;
    localparam int STB_LDB   = 5;
    localparam int STB_LDMA  = 4;
    localparam int STB_ENIMM = 3;
    localparam int STB_ENALU = 2;
    localparam int STB_ENMEM = 1;
    localparam int STB_MEMWR = 0;

    typedef enum logic [2:0] {
        UBR_NEXT     = 3'd0,
        UBR_SPIN     = 3'd1,
        UBR_DISPATCH = 3'd2,
        UBR_FETCH    = 3'd3,
        UBR_BZ       = 3'd4,
        UBR_BNZ      = 3'd5,
        UBR_JUMP     = 3'd6,
        UBR_HALT     = 3'd7
    } ubr_e;

    typedef struct packed {
        logic [1:0] immSel;
        logic [7:0] strobes;
        logic [3:0] aluOp;
        ubr_e       ubr;
        logic [5:0] target;
        logic       rsvd;
    } uinst_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-store load port, condition inputs and decoded control outputs of the sequencer.
interface micro_sequencer_if #(
    parameter int UW = micro_pkg::UW_DEF,
    parameter int AW = micro_pkg::AW_DEF
);
    import micro_pkg::*;

    logic          ucode_we;
    logic [AW-1:0] ucode_addr;
    logic [UW-1:0] ucode_wdata;
    logic          start;
    logic [6:0]    opcode;
    logic          zero;
    logic          mem_busy;
    logic [1:0]    ImmSel;
    logic [7:0]    strobes;
    logic [3:0]    ALUOp;
    logic          running;
    logic          done;

    modport master (
        output ucode_we, ucode_addr, ucode_wdata, start, opcode, zero, mem_busy,
        input  ImmSel, strobes, ALUOp, running, done
    );

    modport slave (
        input  ucode_we, ucode_addr, ucode_wdata, start, opcode, zero, mem_busy,
        output ImmSel, strobes, ALUOp, running, done
    );

endinterface

// File: rtl/micro_sequencer_ucode_store.sv
// Writable control store: synchronous write, combinational read, deliberately never reset
// so a loaded microprogram survives rst_n.
module ucode_store
    import micro_pkg::*;
#(
    parameter int UW = UW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [UW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [UW-1:0] rdata_o
);

    logic [UW-1:0] mem_q [1 << AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: steps a uPC through the control store and drives the
// current microinstruction's control fields onto the datapath while running.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int UW = UW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    micro_sequencer_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] upc_q, upc_d;
    logic          done_q, done_d;
    logic [AW-1:0] upcInc;
    logic [UW-1:0] csRdata;
    logic          storeWe;
    logic          isRun;
    uinst_t        word;
    logic          unusedRsvd;

    // The store only accepts loads while idle so a running program cannot be corrupted.
    assign storeWe = bus.ucode_we && (state_q == ST_IDLE);

    ucode_store #(.UW(UW), .AW(AW)) u_store (
        .clk     (clk),
        .we_i    (storeWe),
        .waddr_i (bus.ucode_addr),
        .wdata_i (bus.ucode_wdata),
        .raddr_i (upc_q),
        .rdata_o (csRdata)
    );

    assign word       = csRdata;
    assign unusedRsvd = word.rsvd;
    assign upcInc     = upc_q + AW'(1);
    assign isRun      = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        done_d  = 1'b0;
        if (!isRun) begin
            if (bus.start) begin
                state_d = ST_RUN;
                upc_d   = '0;
            end
        end else begin
            case (word.ubr)
                UBR_NEXT:     upc_d = upcInc;
                UBR_SPIN:     upc_d = bus.mem_busy ? upc_q : upcInc;
                UBR_DISPATCH: upc_d = AW'({1'b1, bus.opcode[6:2]});
                UBR_FETCH:    upc_d = '0;
                UBR_BZ:       upc_d = bus.zero ? AW'(word.target) : upcInc;
                UBR_BNZ:      upc_d = bus.zero ? upcInc : AW'(word.target);
                UBR_JUMP:     upc_d = AW'(word.target);
                UBR_HALT: begin
                    state_d = ST_IDLE;
                    upc_d   = '0;
                    done_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            done_q  <= done_d;
        end
    end

    // Outputs are gated by state so an asynchronous reset silences the datapath at once.
    assign bus.ImmSel  = isRun ? word.immSel  : 2'b00;
    assign bus.strobes = isRun ? word.strobes : 8'h00;
    assign bus.ALUOp   = isRun ? word.aluOp   : 4'h0;
    assign bus.running = isRun;
    assign bus.done    = done_q;

endmodule
